// File: rtl/button_conditioner.sv
// button_conditioner: synchronises and debounces the active-low UP/DOWN
// push-buttons, then turns each accepted press into a one-cycle active-low
// strobe (with optional auto-repeat) for the up/down counter downstream.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 32,
  parameter int REPEAT_CYCLES   = 8,
  parameter int REPEAT_EN       = 1,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic up_btn,
  input  logic down_btn,
  output logic up,
  output logic down,
  output logic up_held,
  output logic down_held,
  output logic conflict
);

  typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, REPEAT = 2'd2} state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Channel 0 is UP, channel 1 is DOWN.
  logic [1:0] raw;
  logic [1:0] held;
  logic [1:0] req;
  logic       both_held;

  assign raw       = {down_btn, up_btn};
  assign both_held = &held;

  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic             sync_p0;
    logic             sync_q;
    logic             stable;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] rpt_cnt;
    logic [CNT_W-1:0] rpt_cnt_nxt;
    state_t           state;
    state_t           state_nxt;
    logic             req_nxt;

    // Two-flop synchroniser; resets to the released (high) level.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_p0 <= 1'b1;
        sync_q  <= 1'b1;
      end else begin
        sync_p0 <= raw[g];
        sync_q  <= sync_p0;
      end
    end

    // Debounce: accept sync_q only after DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        stable <= 1'b1;
        db_cnt <= '0;
      end else if (sync_q == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable <= sync_q;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_ONE;
      end
    end

    assign held[g] = ~stable;
    assign req[g]  = req_nxt;

    // Press FSM state and repeat timer.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state   <= IDLE;
        rpt_cnt <= '0;
      end else begin
        state   <= state_nxt;
        rpt_cnt <= rpt_cnt_nxt;
      end
    end

    // Next-state and strobe request; repeats are frozen at 0 while both buttons are held.
    always_comb begin
      state_nxt   = state;
      rpt_cnt_nxt = rpt_cnt;
      req_nxt     = 1'b0;
      if (stable) begin
        state_nxt   = IDLE;
        rpt_cnt_nxt = '0;
      end else begin
        case (state)
          IDLE: begin
            req_nxt     = 1'b1;
            rpt_cnt_nxt = '0;
            state_nxt   = HELD;
          end
          HELD: begin
            if ((REPEAT_EN == 0) || both_held) begin
              rpt_cnt_nxt = '0;
            end else if (rpt_cnt == HOLD_LAST) begin
              req_nxt     = 1'b1;
              rpt_cnt_nxt = '0;
              state_nxt   = REPEAT;
            end else begin
              rpt_cnt_nxt = rpt_cnt + CNT_ONE;
            end
          end
          REPEAT: begin
            if (both_held) begin
              rpt_cnt_nxt = '0;
            end else if (rpt_cnt == RPT_LAST) begin
              req_nxt     = 1'b1;
              rpt_cnt_nxt = '0;
            end else begin
              rpt_cnt_nxt = rpt_cnt + CNT_ONE;
            end
          end
          default: begin
            state_nxt   = IDLE;
            rpt_cnt_nxt = '0;
          end
        endcase
      end
    end
  end

  assign up_held   = held[0];
  assign down_held = held[1];

  // Registered strobes; simultaneous requests cancel each other and flag a conflict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up       <= 1'b1;
      down     <= 1'b1;
      conflict <= 1'b0;
    end else begin
      up       <= ~(req[0] & ~req[1]);
      down     <= ~(req[1] & ~req[0]);
      conflict <= req[0] & req[1];
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: scenario tasks drive the buttons and push
// the edge numbers at which strobes/conflicts are due; a monitor pops them.
module tb_button_conditioner;

  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int RPT  = 4;

  logic clk = 1'b0;
  logic reset;
  logic up_btn;
  logic down_btn;
  logic up;
  logic down;
  logic up_held;
  logic down_held;
  logic conflict;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;
  bit mon_en   = 1'b0;

  // Scoreboard: edge numbers after which a low strobe / high conflict is due.
  int exp_up[$];
  int exp_dn[$];
  int exp_cf[$];

  logic mon_u;
  logic mon_d;
  logic mon_c;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (RPT),
    .REPEAT_EN      (1),
    .CNT_W          (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .up_btn   (up_btn),
    .down_btn (down_btn),
    .up       (up),
    .down     (down),
    .up_held  (up_held),
    .down_held(down_held),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: every cycle, each output must match the scoreboard's expectation.
  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      mon_u = 1'b1;
      mon_d = 1'b1;
      mon_c = 1'b0;
      if (exp_up.size() > 0 && exp_up[0] == edge_n) begin
        mon_u = 1'b0;
        void'(exp_up.pop_front());
      end
      if (exp_dn.size() > 0 && exp_dn[0] == edge_n) begin
        mon_d = 1'b0;
        void'(exp_dn.pop_front());
      end
      if (exp_cf.size() > 0 && exp_cf[0] == edge_n) begin
        mon_c = 1'b1;
        void'(exp_cf.pop_front());
      end
      n_checks++;
      if (up === mon_u) n_pass++;
      else $display("FAIL up_strobe edge %0d: got %b expected %b", edge_n, up, mon_u);
      n_checks++;
      if (down === mon_d) n_pass++;
      else $display("FAIL down_strobe edge %0d: got %b expected %b", edge_n, down, mon_d);
      n_checks++;
      if (conflict === mon_c) n_pass++;
      else $display("FAIL conflict edge %0d: got %b expected %b", edge_n, conflict, mon_c);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 6; i++) begin
      up_btn   = i[0];
      down_btn = ~i[0];
      tick(1);
      n_checks++;
      if ({up, down, up_held, down_held, conflict} === 5'b11000) n_pass++;
      else $display("FAIL reset_hold cycle %0d: got %b expected 11000", i,
                    {up, down, up_held, down_held, conflict});
    end
    up_btn   = 1'b1;
    down_btn = 1'b1;
    tick(1);
    reset  = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      n_checks++;
      if ({up, down, up_held, down_held, conflict} === 5'b11000) n_pass++;
      else $display("FAIL reset_release cycle %0d: got %b expected 11000", i,
                    {up, down, up_held, down_held, conflict});
    end
  endtask

  task automatic test_clean_press;
    int t0;
    int r;
    t0 = edge_n;
    up_btn = 1'b0;
    exp_up.push_back(t0 + DB + 3);
    tick(DB + 1);
    n_checks++;
    if (up_held === 1'b0) n_pass++;
    else $display("FAIL press_held_early: got %b expected 0", up_held);
    tick(1);
    n_checks++;
    if (up_held === 1'b1) n_pass++;
    else $display("FAIL press_held_set: got %b expected 1", up_held);
    tick(1);
    r = edge_n;
    up_btn = 1'b1;
    tick(DB + 1);
    n_checks++;
    if (up_held === 1'b1) n_pass++;
    else $display("FAIL release_held_early edge %0d: got %b expected 1", edge_n - r, up_held);
    tick(1);
    n_checks++;
    if (up_held === 1'b0) n_pass++;
    else $display("FAIL release_held_clear: got %b expected 0", up_held);
    tick(4);
    n_checks++;
    if (exp_up.size() == 0) n_pass++;
    else $display("FAIL clean_press_pending: got %0d left expected 0", exp_up.size());
    exp_up.delete();
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 20; i++) begin
      up_btn = ((i % 4) < 2) ? 1'b0 : 1'b1;
      tick(1);
      n_checks++;
      if (up_held === 1'b0) n_pass++;
      else $display("FAIL bounce_held cycle %0d: got %b expected 0", i, up_held);
    end
    up_btn = 1'b1;
    tick(8);
    n_checks++;
    if (up_held === 1'b0) n_pass++;
    else $display("FAIL bounce_settle: got %b expected 0", up_held);
  endtask

  task automatic test_auto_repeat;
    int t0;
    int k;
    t0 = edge_n;
    down_btn = 1'b0;
    // Release after 40 cycles: down_held falls 6 edges later (t0+46); the FSM
    // still sees the button held through edge t0+46, so repeats run up to t0+43.
    k = DB + 3;
    exp_dn.push_back(t0 + k);
    k = k + HOLD;
    while (k <= 40 + DB + 2) begin
      exp_dn.push_back(t0 + k);
      k = k + RPT;
    end
    tick(40);
    down_btn = 1'b1;
    tick(DB + 1);
    n_checks++;
    if (down_held === 1'b1) n_pass++;
    else $display("FAIL repeat_release_early: got %b expected 1", down_held);
    tick(1);
    n_checks++;
    if (down_held === 1'b0) n_pass++;
    else $display("FAIL repeat_release_clear: got %b expected 0", down_held);
    tick(10);
    n_checks++;
    if (exp_dn.size() == 0) n_pass++;
    else $display("FAIL auto_repeat_pending: got %0d left expected 0", exp_dn.size());
    exp_dn.delete();
  endtask

  task automatic test_simultaneous;
    int t0;
    int r;
    t0 = edge_n;
    up_btn   = 1'b0;
    down_btn = 1'b0;
    exp_cf.push_back(t0 + DB + 3);
    tick(DB + 2);
    n_checks++;
    if ({up_held, down_held} === 2'b11) n_pass++;
    else $display("FAIL simul_held: got %b expected 11", {up_held, down_held});
    tick(30 - (DB + 2));
    r = edge_n;
    down_btn = 1'b1;
    // down_held falls at r+6; up's hold timer restarts from 0 on the next edge.
    exp_up.push_back(r + DB + 2 + HOLD);
    exp_up.push_back(r + DB + 2 + HOLD + RPT);
    tick(DB + 1);
    n_checks++;
    if (down_held === 1'b1) n_pass++;
    else $display("FAIL simul_down_early: got %b expected 1", down_held);
    tick(1);
    n_checks++;
    if (down_held === 1'b0) n_pass++;
    else $display("FAIL simul_down_clear: got %b expected 0", down_held);
    tick(HOLD);
    up_btn = 1'b1;
    tick(12);
    n_checks++;
    if (exp_up.size() == 0 && exp_cf.size() == 0) n_pass++;
    else $display("FAIL simul_pending: got %0d/%0d left expected 0/0", exp_up.size(), exp_cf.size());
    exp_up.delete();
    exp_cf.delete();
  endtask

  task automatic test_press_while_held;
    int t0;
    t0 = edge_n;
    up_btn = 1'b0;
    exp_up.push_back(t0 + DB + 3);
    exp_up.push_back(t0 + DB + 3 + HOLD);
    tick(10);
    down_btn = 1'b0;
    // down_held rises at t0+16: its press strobe goes out, up's repeats freeze.
    exp_dn.push_back(t0 + 10 + DB + 3);
    tick(15);
    up_btn   = 1'b1;
    down_btn = 1'b1;
    tick(DB + 2);
    n_checks++;
    if ({up_held, down_held} === 2'b00) n_pass++;
    else $display("FAIL pwh_release: got %b expected 00", {up_held, down_held});
    tick(6);
    n_checks++;
    if (exp_up.size() == 0 && exp_dn.size() == 0) n_pass++;
    else $display("FAIL pwh_pending: got %0d/%0d left expected 0/0", exp_up.size(), exp_dn.size());
    exp_up.delete();
    exp_dn.delete();
  endtask

  task automatic test_reset_mid_hold;
    int t0;
    int t1;
    t0 = edge_n;
    up_btn = 1'b0;
    exp_up.push_back(t0 + DB + 3);
    exp_up.push_back(t0 + DB + 3 + HOLD);
    exp_up.push_back(t0 + DB + 3 + HOLD + RPT);
    tick(20);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({up, up_held, conflict} === 3'b100) n_pass++;
    else $display("FAIL mid_reset_async: got %b expected 100", {up, up_held, conflict});
    for (int i = 0; i < 2; i++) begin
      tick(1);
      n_checks++;
      if ({up, up_held} === 2'b10) n_pass++;
      else $display("FAIL mid_reset_cycle %0d: got %b expected 10", i, {up, up_held});
    end
    reset = 1'b1;
    t1 = edge_n;
    exp_up.push_back(t1 + DB + 3);
    tick(DB + 3);
    up_btn = 1'b1;
    tick(DB + 2);
    n_checks++;
    if (up_held === 1'b0) n_pass++;
    else $display("FAIL mid_reset_release: got %b expected 0", up_held);
    tick(4);
    n_checks++;
    if (exp_up.size() == 0) n_pass++;
    else $display("FAIL mid_reset_pending: got %0d left expected 0", exp_up.size());
    exp_up.delete();
  endtask

  initial begin
    up_btn   = 1'b1;
    down_btn = 1'b1;
    reset    = 1'b1;
    #1;
    reset    = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_simultaneous();
    test_press_while_held();
    test_reset_mid_hold();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", n_checks, n_pass);
    $fatal(1);
  end

endmodule
